// File: rtl/axis_rr_arbiter_if.sv
// AXI-Stream bundle for axis_rr_arbiter: N requester streams in, one granted stream out.
// slave = arbiter view, master = the environment driving requesters and sinking the output.
interface axis_rr_arbiter_if #(
  parameter int PAR_WDATA_BYTE = 2,
  parameter int PAR_NUM_REQ    = 4
);
  localparam int TIDW = $clog2(PAR_NUM_REQ);
  localparam int DW   = 8 * PAR_WDATA_BYTE;

  logic [PAR_NUM_REQ-1:0][DW-1:0] s_axis_tdata;
  logic [PAR_NUM_REQ-1:0]         s_axis_tvalid;
  logic [PAR_NUM_REQ-1:0]         s_axis_tready;
  logic [DW-1:0]                  m_axis_tdata;
  logic [TIDW-1:0]                m_axis_tid;
  logic                           m_axis_tvalid;
  logic                           m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tid, m_axis_tvalid
  );
  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tid, m_axis_tvalid
  );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Round-robin N:1 AXI-Stream arbiter with a single full-throughput output register.
// Define AXIS_RR_ARBITER_CNT_EN to add per-requester 16-bit accepted-beat counters (grant_cnt).
module axis_rr_arbiter #(
  parameter int PAR_WDATA_BYTE = 2,
  parameter int PAR_NUM_REQ    = 4
) (
  input  logic                aclk,
  input  logic                aresetn,
  axis_rr_arbiter_if.slave    bus
`ifdef AXIS_RR_ARBITER_CNT_EN
  ,
  output logic [PAR_NUM_REQ-1:0][15:0] grant_cnt
`endif
);
  localparam int TIDW = $clog2(PAR_NUM_REQ);
  localparam int DW   = 8 * PAR_WDATA_BYTE;

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]             state;
  logic [TIDW-1:0]        last_grant;
  logic [TIDW-1:0]        sel_idx;
  logic                   sel_vld;
  logic                   load_en;
  logic [PAR_NUM_REQ-1:0] ready;
  logic [DW-1:0]          data_q;
  logic [TIDW-1:0]        tid_q;

  // Search starts one past the last winner; only tvalid and last_grant feed it,
  // so tready never depends on data.
  always_comb begin
    logic [TIDW-1:0] idx;
    sel_vld = 1'b0;
    sel_idx = '0;
    idx     = '0;
    for (int k = 1; k <= PAR_NUM_REQ; k++) begin
      idx = TIDW'((int'(last_grant) + k) % PAR_NUM_REQ);
      if (!sel_vld && bus.s_axis_tvalid[idx]) begin
        sel_vld = 1'b1;
        sel_idx = idx;
      end
    end
  end

  assign load_en = (state == EMPTY) || bus.m_axis_tready;

  always_comb begin
    ready = '0;
    if (aresetn && load_en && sel_vld) ready[sel_idx] = 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= EMPTY;
      data_q     <= '0;
      tid_q      <= '0;
      last_grant <= TIDW'(PAR_NUM_REQ - 1);
    end else if (load_en) begin
      if (sel_vld) begin
        state      <= FULL;
        data_q     <= bus.s_axis_tdata[sel_idx];
        tid_q      <= sel_idx;
        last_grant <= sel_idx;
      end else begin
        state      <= EMPTY;
      end
    end
  end

  assign bus.s_axis_tready = ready;
  assign bus.m_axis_tdata  = data_q;
  assign bus.m_axis_tid    = tid_q;
  assign bus.m_axis_tvalid = (state == FULL);

`ifdef AXIS_RR_ARBITER_CNT_EN
  for (genvar g = 0; g < PAR_NUM_REQ; g++) begin : g_cnt
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)      grant_cnt[g] <= '0;
      else if (ready[g]) grant_cnt[g] <= grant_cnt[g] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_axis_rr_arbiter;
  localparam int NREQ = 4;

  typedef struct packed {
    logic [1:0]  tid;
    logic [15:0] data;
  } beat_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  logic mon_en = 1'b1;
  beat_t exp_q[$];

  axis_rr_arbiter_if #(.PAR_WDATA_BYTE(2), .PAR_NUM_REQ(NREQ)) bus();

`ifdef AXIS_RR_ARBITER_CNT_EN
  logic [NREQ-1:0][15:0] grant_cnt;
`endif

  axis_rr_arbiter #(.PAR_WDATA_BYTE(2), .PAR_NUM_REQ(NREQ)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
`ifdef AXIS_RR_ARBITER_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output side: one pop per handshake on the output.
  always @(negedge aclk) begin
    if (mon_en && aresetn && bus.m_axis_tvalid && bus.m_axis_tready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {14'd0, bus.m_axis_tid, bus.m_axis_tdata}, 32'hFFFF_FFFF);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("out_tid", 32'(bus.m_axis_tid), 32'(e.tid));
        check("out_data", 32'(bus.m_axis_tdata), 32'(e.data));
      end
    end
  end

  task automatic set_data(input logic [15:0] base);
    for (int i = 0; i < NREQ; i++) bus.s_axis_tdata[i] = base + 16'(i);
  endtask

  task automatic next_cycle();
    @(posedge aclk);
    #1;
  endtask

  // Drive one cycle; exp_g < 0 means no grant is expected this cycle.
  task automatic beat(input logic [3:0] vld, input logic rdy, input int exp_g,
                      input logic [15:0] exp_data, input bit push = 1'b1);
    logic [3:0] exp_rdy;
    bus.s_axis_tvalid = vld;
    bus.m_axis_tready = rdy;
    #1;
    exp_rdy = (exp_g < 0) ? 4'b0000 : 4'(1 << exp_g);
    check("s_tready", 32'(bus.s_axis_tready), 32'(exp_rdy));
    if (exp_g >= 0 && push) exp_q.push_back('{tid: 2'(exp_g), data: exp_data});
    next_cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_axis_tvalid = 4'hF;
    bus.m_axis_tready = 1'b1;
    set_data(16'h0010);
    #12;
    check("rst_tvalid", 32'(bus.m_axis_tvalid), 0);
    check("rst_tdata", 32'(bus.m_axis_tdata), 0);
    check("rst_tid", 32'(bus.m_axis_tid), 0);
    check("rst_tready", 32'(bus.s_axis_tready), 0);
    aresetn = 1'b1;

    // All four valid: strict rotation starting at 0.
    for (int i = 0; i < 8; i++) beat(4'hF, 1'b1, i % 4, 16'h0010 + 16'(i % 4));

    // Lone requester 2 streams with no bubbles.
    for (int n = 0; n < 6; n++) begin
      bus.s_axis_tdata[2] = 16'hA000 + 16'(n);
      beat(4'b0100, 1'b1, 2, 16'hA000 + 16'(n));
    end

    // Requesters 1 and 3 alternate once last_grant=3.
    set_data(16'h3100);
    beat(4'b1000, 1'b1, 3, 16'h3103);
    for (int i = 0; i < 4; i++) beat(4'b1010, 1'b1, (i % 2) ? 3 : 1, (i % 2) ? 16'h3103 : 16'h3101);

    // Stall while holding tid=1 / 0x1234.
    bus.s_axis_tdata[1] = 16'h1234;
    beat(4'b0010, 1'b1, 1, 16'h1234);
    set_data(16'h0040);
    for (int i = 0; i < 5; i++) begin
      check("stall_tvalid", 32'(bus.m_axis_tvalid), 1);
      check("stall_tid", 32'(bus.m_axis_tid), 1);
      check("stall_tdata", 32'(bus.m_axis_tdata), 32'h1234);
      beat(4'hF, 1'b0, -1, 16'h0);
    end
    beat(4'hF, 1'b1, 2, 16'h0042);
    beat(4'hF, 1'b1, 3, 16'h0043);

    // Idle drains to EMPTY and keeps priority.
    beat(4'h0, 1'b1, -1, 16'h0);
    check("idle_empty", 32'(bus.m_axis_tvalid), 0);
    beat(4'h0, 1'b1, -1, 16'h0);
    check("idle_stay_empty", 32'(bus.m_axis_tvalid), 0);
    beat(4'hF, 1'b1, 0, 16'h0040);
    beat(4'h0, 1'b1, -1, 16'h0);

    // Reset while FULL drops the held beat at once.
    beat(4'hF, 1'b0, 1, 16'h0041, 1'b0);
    check("pre_rst_tvalid", 32'(bus.m_axis_tvalid), 1);
    check("pre_rst_tid", 32'(bus.m_axis_tid), 1);
    #1 aresetn = 1'b0;
    #1;
    check("mid_rst_tvalid", 32'(bus.m_axis_tvalid), 0);
    check("mid_rst_tdata", 32'(bus.m_axis_tdata), 0);
    check("mid_rst_tready", 32'(bus.s_axis_tready), 0);
    aresetn = 1'b1;
    beat(4'hF, 1'b1, 0, 16'h0040);
    beat(4'hF, 1'b1, 1, 16'h0041);
    beat(4'h0, 1'b1, -1, 16'h0);
    beat(4'h0, 1'b1, -1, 16'h0);
    check("queue_drained", 32'(exp_q.size()), 0);

`ifdef AXIS_RR_ARBITER_CNT_EN
    mon_en = 1'b0;
    #1 aresetn = 1'b0;
    #1 aresetn = 1'b1;
    bus.s_axis_tvalid = 4'b0001;
    bus.m_axis_tready = 1'b1;
    repeat (65537) @(posedge aclk);
    #1 bus.s_axis_tvalid = 4'b0000;
    next_cycle();
    check("cnt0_wrap", 32'(grant_cnt[0]), 1);
    for (int i = 1; i < NREQ; i++) check("cnt_other", 32'(grant_cnt[i]), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
